mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sits between the PC/IF_ID and EX_MEM/MEM_WB pipeline registers on one side and the memory on the other.
- Sequences each access as a request/ack handshake.
- Drives hold signals that stall the pipeline while an access is pending.

---
 rtl/arb_pkg.sv | 24 ++
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/arb_sat_counter.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and defaults for the IF/MEM memory port arbiter.
// Holds the FSM state, grant encoding, default limits and a counter-width helper.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_I,
        GNT_D
    } grant_t;

    localparam int DEF_MAX_D_STREAK = 4;
    localparam int DEF_TIMEOUT      = 16;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side requests plus memory-side strobes of the shared memory port.
// slave = the arbiter, master = the pipeline and memory surrounding it.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;

    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;

    logic          hold_if;
    logic          hold_mem;
    logic          err;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport slave (
        input  if_req, if_addr, d_read, d_write, d_addr, d_wdata,
        input  mem_rdata, mem_ready,
        output if_rdata, if_ack, d_rdata, d_ack, hold_if, hold_mem, err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_read, d_write, d_addr, d_wdata,
        output mem_rdata, mem_ready,
        input  if_rdata, if_ack, d_rdata, d_ack, hold_if, hold_mem, err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Output is the registered count, updated one cycle after clr_i/inc_i.
module arb_sat_counter
    import arb_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W   = cnt_width(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store; 2-cycle best case.
// Requesters stall on hold_if/hold_mem until their ack; a silent memory is aborted with err.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_D_STREAK = DEF_MAX_D_STREAK,
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    localparam int SW = cnt_width(MAX_D_STREAK);
    localparam int TW = cnt_width(TIMEOUT);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    arb_state_t    state_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          if_ack_q;
    logic          d_ack_q;
    logic          err_q;

    grant_t        grant_d;
    logic          d_pend;
    logic          turnaround;
    logic          busy;
    logic          tmo_hit;
    logic          streak_clr;
    logic          streak_inc;
    logic          tmo_clr;
    logic          tmo_inc;
    logic [SW-1:0] streak_cnt;
    logic [TW-1:0] tmo_cnt;

    assign d_pend = bus.d_read | bus.d_write;
    assign busy   = (state_q != IDLE);

    // The ack/err cycle still shows the finished request, so no grant is made then.
    assign turnaround = if_ack_q | d_ack_q | err_q;

    always_comb begin
        grant_d = GNT_NONE;
        if ((state_q == IDLE) && !turnaround) begin
            if (d_pend && !((streak_cnt == STREAK_MAX) && bus.if_req)) begin
                grant_d = GNT_D;
            end else if (bus.if_req) begin
                grant_d = GNT_I;
            end
        end
    end

    assign streak_inc = (grant_d == GNT_D) && bus.if_req;
    assign streak_clr = (grant_d == GNT_I) || ((grant_d == GNT_D) && !bus.if_req);
    assign tmo_clr    = (grant_d != GNT_NONE);
    assign tmo_inc    = busy && !bus.mem_ready;
    assign tmo_hit    = busy && !bus.mem_ready && (tmo_cnt == TMO_LAST);

    arb_sat_counter #(.MAX(MAX_D_STREAK), .W(SW)) u_streak (
        .clk   (clk),
        .rst   (rst),
        .clr_i (streak_clr),
        .inc_i (streak_inc),
        .cnt_o (streak_cnt)
    );

    arb_sat_counter #(.MAX(TIMEOUT), .W(TW)) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clr_i (tmo_clr),
        .inc_i (tmo_inc),
        .cnt_o (tmo_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    case (grant_d)
                        GNT_D: begin
                            mem_addr_q  <= bus.d_addr;
                            mem_wdata_q <= bus.d_wdata;
                            mem_we_q    <= bus.d_write;
                            mem_req_q   <= 1'b1;
                            state_q     <= BUSY_D;
                        end
                        GNT_I: begin
                            mem_addr_q  <= bus.if_addr;
                            mem_wdata_q <= '0;
                            mem_we_q    <= 1'b0;
                            mem_req_q   <= 1'b1;
                            state_q     <= BUSY_I;
                        end
                        default: ;
                    endcase
                end
                BUSY_I, BUSY_D: begin
                    if (bus.mem_ready) begin
                        if (state_q == BUSY_I) begin
                            if_rdata_q <= bus.mem_rdata;
                            if_ack_q   <= 1'b1;
                        end else begin
                            d_rdata_q <= bus.mem_rdata;
                            d_ack_q   <= 1'b1;
                        end
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= IDLE;
                    end else if (tmo_hit) begin
                        err_q     <= 1'b1;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.err       = err_q;
    assign bus.hold_if   = bus.if_req & ~if_ack_q;
    assign bus.hold_mem  = d_pend & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by a randomized run checked against a request-level model.
module tb_mem_port_arbiter;

    localparam int MAXS = 4;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(
        .MAX_D_STREAK (MAXS),
        .TIMEOUT      (TMO),
        .AW           (32),
        .DW           (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  seq;
        int          ng;
        logic        prev;
        int          busyc;
        int          acks;
        logic        got_err;
        logic        if_out, d_out, d_isw, exp_if, exp_d, prev_req, rdy;
        logic [31:0] if_a, d_a, d_wd;
        int          streak, who, g, eg, bw, if_wait, d_wait, op;

        rst           = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
        step();
        step();
        chk1("rst_mem_req", bus.mem_req, 1'b0);
        chk1("rst_mem_we", bus.mem_we, 1'b0);
        chk1("rst_acks", bus.if_ack | bus.d_ack, 1'b0);
        chk1("rst_err", bus.err, 1'b0);
        chk32("rst_mem_addr", bus.mem_addr, 32'h0);
        chk32("rst_if_rdata", bus.if_rdata, 32'h0);
        chk32("rst_d_rdata", bus.d_rdata, 32'h0);
        rst = 1'b0;

        // mem_ready while idle must do nothing
        bus.mem_ready = 1'b1;
        step();
        step();
        chk1("idle_ready_req", bus.mem_req, 1'b0);
        chk1("idle_ready_ack", bus.if_ack | bus.d_ack, 1'b0);
        bus.mem_ready = 1'b0;

        // lone fetch
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h10;
        bus.mem_rdata = 32'h8C220004;
        #1;
        chk1("t1_hold_if_req", bus.hold_if, 1'b1);
        step();
        chk1("t1_mem_req", bus.mem_req, 1'b1);
        chk32("t1_mem_addr", bus.mem_addr, 32'h10);
        chk1("t1_mem_we", bus.mem_we, 1'b0);
        chk1("t1_no_early_ack", bus.if_ack, 1'b0);
        chk1("t1_hold_if_busy", bus.hold_if, 1'b1);
        bus.mem_ready = 1'b1;
        step();
        chk1("t1_if_ack", bus.if_ack, 1'b1);
        chk32("t1_if_rdata", bus.if_rdata, 32'h8C220004);
        chk1("t1_req_drop", bus.mem_req, 1'b0);
        chk1("t1_hold_if_ack", bus.hold_if, 1'b0);
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        step();
        chk1("t1_ack_pulse", bus.if_ack, 1'b0);
        chk32("t1_rdata_held", bus.if_rdata, 32'h8C220004);

        // simultaneous fetch and load
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h20;
        bus.d_read  = 1'b1;
        bus.d_addr  = 32'h40;
        step();
        chk1("t2_mem_req", bus.mem_req, 1'b1);
        chk32("t2_data_first", bus.mem_addr, 32'h40);
        chk1("t2_hold_mem", bus.hold_mem, 1'b1);
        chk1("t2_hold_if", bus.hold_if, 1'b1);
        bus.mem_rdata = 32'h00001234;
        bus.mem_ready = 1'b1;
        step();
        chk1("t2_d_ack", bus.d_ack, 1'b1);
        chk32("t2_d_rdata", bus.d_rdata, 32'h00001234);
        chk1("t2_hold_mem_ack", bus.hold_mem, 1'b0);
        bus.d_read    = 1'b0;
        bus.mem_ready = 1'b0;
        step();
        chk1("t2_turnaround", bus.mem_req, 1'b0);
        step();
        chk1("t2_if_granted", bus.mem_req, 1'b1);
        chk32("t2_if_addr", bus.mem_addr, 32'h20);
        bus.mem_rdata = 32'h0BADF00D;
        bus.mem_ready = 1'b1;
        step();
        chk1("t2_if_ack", bus.if_ack, 1'b1);
        chk32("t2_if_rdata", bus.if_rdata, 32'h0BADF00D);
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        step();

        // starvation guard
        bus.d_write   = 1'b1;
        bus.d_addr    = 32'h100;
        bus.d_wdata   = 32'h11;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h200;
        bus.mem_ready = 1'b1;
        seq  = '0;
        ng   = 0;
        prev = 1'b0;
        for (int c = 0; c < 60 && ng < 5; c++) begin
            step();
            if (bus.mem_req && !prev) begin
                seq[ng] = (bus.mem_addr == 32'h100);
                ng++;
            end
            prev = bus.mem_req;
        end
        chk32("t3_grants", 32'(ng), 32'd5);
        chk32("t3_order", 32'(seq), 32'h0000000F);
        chk32("t3_streak_clear", 32'(dut.streak_cnt), 32'd0);
        step();
        chk1("t3_if_ack", bus.if_ack, 1'b1);
        bus.if_req    = 1'b0;
        bus.d_write   = 1'b0;
        bus.mem_ready = 1'b0;
        step();

        // timeout
        bus.d_read  = 1'b1;
        bus.d_addr  = 32'h80;
        busyc   = 0;
        acks    = 0;
        got_err = 1'b0;
        for (int c = 0; c < 40 && !got_err; c++) begin
            step();
            if (bus.mem_req) busyc++;
            if (bus.d_ack) acks++;
            if (bus.err) got_err = 1'b1;
        end
        chk1("t4_err", got_err, 1'b1);
        chk32("t4_busy_cycles", 32'(busyc), 32'(TMO));
        chk1("t4_req_fall", bus.mem_req, 1'b0);
        chk32("t4_no_ack", 32'(acks), 32'd0);
        step();
        chk1("t4_err_pulse", bus.err, 1'b0);
        chk1("t4_turnaround", bus.mem_req, 1'b0);
        step();
        chk1("t4_regrant", bus.mem_req, 1'b1);
        chk32("t4_regrant_addr", bus.mem_addr, 32'h80);
        bus.mem_ready = 1'b1;
        step();
        chk1("t4_d_ack", bus.d_ack, 1'b1);
        bus.d_read    = 1'b0;
        bus.mem_ready = 1'b0;
        step();

        // reset in the middle of a data access
        bus.d_read  = 1'b1;
        bus.d_addr  = 32'h90;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h30;
        step();
        chk32("t5_data_addr", bus.mem_addr, 32'h90);
        rst        = 1'b1;
        bus.d_read = 1'b0;
        step();
        chk1("t5_rst_req", bus.mem_req, 1'b0);
        chk1("t5_rst_ack", bus.d_ack | bus.if_ack, 1'b0);
        chk32("t5_rst_addr", bus.mem_addr, 32'h0);
        rst = 1'b0;
        step();
        chk1("t5_if_grant", bus.mem_req, 1'b1);
        chk32("t5_if_addr", bus.mem_addr, 32'h30);
        bus.mem_ready = 1'b1;
        step();
        chk1("t5_if_ack", bus.if_ack, 1'b1);
        chk1("t5_no_d_ack", bus.d_ack, 1'b0);
        bus.if_req    = 1'b0;
        bus.mem_ready = 1'b0;
        step();

        // read and write together
        bus.d_read  = 1'b1;
        bus.d_write = 1'b1;
        bus.d_addr  = 32'hA0;
        bus.d_wdata = 32'hDEADBEEF;
        step();
        chk1("t6_mem_req", bus.mem_req, 1'b1);
        chk1("t6_mem_we", bus.mem_we, 1'b1);
        chk32("t6_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        bus.mem_ready = 1'b1;
        step();
        chk1("t6_d_ack", bus.d_ack, 1'b1);
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.mem_ready = 1'b0;
        step();
        chk1("t6_ack_once", bus.d_ack, 1'b0);

        // randomized traffic
        if_out = 1'b0; d_out = 1'b0; d_isw = 1'b0;
        exp_if = 1'b0; exp_d = 1'b0; prev_req = bus.mem_req;
        if_a = '0; d_a = '0; d_wd = '0;
        streak = 0; who = 0; bw = 0; if_wait = 0; d_wait = 0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            step();
            chk1("r_if_ack", bus.if_ack, exp_if);
            chk1("r_d_ack", bus.d_ack, exp_d);
            chk1("r_err", bus.err, 1'b0);
            chk1("r_hold_if", bus.hold_if, if_out & ~exp_if);
            chk1("r_hold_mem", bus.hold_mem, d_out & ~exp_d);
            if (exp_if) begin
                chk32("r_if_rdata", bus.if_rdata, hash(if_a));
                chk1("r_if_wait", if_wait <= 80, 1'b1);
                if_out = 1'b0;
            end
            if (exp_d) begin
                chk32("r_d_rdata", bus.d_rdata, hash(d_a));
                chk1("r_d_wait", d_wait <= 80, 1'b1);
                d_out = 1'b0;
            end
            if (bus.mem_req && !prev_req) begin
                g  = bus.mem_addr[15] ? 2 : 1;
                eg = (d_out && !(streak == MAXS && if_out)) ? 2 : (if_out ? 1 : 0);
                chk32("r_grant", 32'(g), 32'(eg));
                if (g == 2) begin
                    chk32("r_d_addr", bus.mem_addr, d_a);
                    chk1("r_d_we", bus.mem_we, d_isw);
                    chk32("r_d_wdata", bus.mem_wdata, d_wd);
                    streak = if_out ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
                end else begin
                    chk32("r_if_addr", bus.mem_addr, if_a);
                    chk1("r_if_we", bus.mem_we, 1'b0);
                    streak = 0;
                end
                who = g;
                bw  = 0;
            end
            prev_req = bus.mem_req;

            if (!if_out && $urandom_range(0, 2) == 0) begin
                if_out  = 1'b1;
                if_a    = {16'h0000, 4'h1, 10'($urandom), 2'b00};
                if_wait = 0;
            end
            if (!d_out && $urandom_range(0, 2) == 0) begin
                d_out  = 1'b1;
                op     = $urandom_range(0, 2);
                d_isw  = (op != 0);
                d_a    = {16'h0000, 1'b1, 13'($urandom), 2'b00};
                d_wd   = $urandom;
                d_wait = 0;
                bus.d_read  = (op != 1);
                bus.d_write = d_isw;
            end else if (!d_out) begin
                bus.d_read  = 1'b0;
                bus.d_write = 1'b0;
            end
            if (if_out) if_wait++;
            if (d_out) d_wait++;
            bus.if_req  = if_out;
            bus.if_addr = if_a;
            bus.d_addr  = d_a;
            bus.d_wdata = d_wd;

            if (bus.mem_req) begin
                bw++;
                rdy = (bw >= 4) || ($urandom_range(0, 1) == 1);
            end else begin
                rdy = ($urandom_range(0, 3) == 0);
            end
            bus.mem_ready = rdy;
            bus.mem_rdata = hash(bus.mem_addr);
            exp_if = bus.mem_req && rdy && (who == 1);
            exp_d  = bus.mem_req && rdy && (who == 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
